// File: rtl/adc_st_packetizer_pkg.sv
// rtl/adc_st_packetizer_pkg.sv - shared constants and types for the ADC Avalon-ST packetizer
package adc_st_pkg;

  localparam int SAMPLE_W = 16;
  localparam int BEAT_W   = 512;
  localparam int SPB      = BEAT_W / SAMPLE_W;
  localparam int EMPTY_W  = 6;
  localparam int LANE_W   = $clog2(SPB);

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    DRAIN
  } state_t;

  typedef struct packed {
    logic [BEAT_W-1:0]  data;
    logic               sop;
    logic               eop;
    logic [EMPTY_W-1:0] empty;
  } beat_t;

  // Two bytes per lane left unfilled above last_lane.
  function automatic logic [EMPTY_W-1:0] empty_bytes(input logic [LANE_W-1:0] last_lane);
    logic [LANE_W-1:0] free_lanes;
    free_lanes = LANE_W'(SPB - 1) - last_lane;
    return {free_lanes, 1'b0};
  endfunction

endpackage

// File: rtl/adc_st_packetizer_if.sv
// rtl/adc_st_packetizer_if.sv - Avalon-ST beat stream toward the ADC FIFO sink
interface adc_st_packetizer_if;
  import adc_st_pkg::*;

  logic [BEAT_W-1:0]  st_data;
  logic               st_valid;
  logic               st_ready;
  logic               st_sop;
  logic               st_eop;
  logic [EMPTY_W-1:0] st_empty;

  modport master (
    output st_data, st_valid, st_sop, st_eop, st_empty,
    input  st_ready
  );

  modport slave (
    input  st_data, st_valid, st_sop, st_eop, st_empty,
    output st_ready
  );

endinterface

// File: rtl/adc_st_packetizer_beat_buf.sv
// rtl/adc_st_packetizer_beat_buf.sv - 2-entry zero-bubble beat FIFO with registered outputs
module adc_beat_buf
  import adc_st_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  in_valid,
  output logic  in_ready,
  input  beat_t in_beat,
  output logic  out_valid,
  input  logic  out_ready,
  output beat_t out_beat
);

  beat_t head;
  beat_t tail;
  logic  head_valid;
  logic  tail_valid;
  logic  push;
  logic  pop;

  // in_ready depends only on state, so no combinational path from out_ready.
  assign in_ready  = !tail_valid;
  assign out_valid = head_valid;
  assign out_beat  = head;
  assign push      = in_valid && !tail_valid;
  assign pop       = head_valid && out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      head       <= '0;
      tail       <= '0;
      head_valid <= 1'b0;
      tail_valid <= 1'b0;
    end else if (tail_valid) begin
      if (pop) begin
        head       <= tail;
        tail_valid <= 1'b0;
      end
    end else if (push) begin
      if (!head_valid || pop) begin
        head       <= in_beat;
        head_valid <= 1'b1;
      end else begin
        tail       <= in_beat;
        tail_valid <= 1'b1;
      end
    end else if (pop) begin
      head_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/adc_st_packetizer.sv
// rtl/adc_st_packetizer.sv - packs triggered 16-bit ADC captures into framed 512-bit Avalon-ST beats
module adc_st_packetizer
  import adc_st_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                trig,
  input  logic [15:0]         pkt_len,
  input  logic [SAMPLE_W-1:0] adc_data,
  input  logic                adc_valid,
  adc_st_packetizer_if.master st,
  output logic                busy,
  output logic [31:0]         overflow_cnt,
  output logic [31:0]         pkt_cnt
);

  state_t            state;
  logic [15:0]       left;
  logic [LANE_W-1:0] lane;
  logic              first_beat;
  beat_t             pack;
  logic              pack_full;

  beat_t             cur_beat;
  beat_t             buf_in;
  beat_t             buf_out;
  logic              buf_in_valid;
  logic              buf_in_ready;
  logic              buf_out_valid;
  logic [BEAT_W-1:0] merged;
  logic              take;
  logic              drop;
  logic              final_sample;
  logic              close;
  logic              eop_xfer;

  assign take         = (state == CAPTURE) && adc_valid && !pack_full;
  assign drop         = (state == CAPTURE) && adc_valid && pack_full;
  assign final_sample = (left == 16'd1);
  assign close        = take && ((lane == LANE_W'(SPB - 1)) || final_sample);
  assign eop_xfer     = buf_out_valid && st.st_ready && buf_out.eop;

  // Lane 0 starts a fresh beat; sample k lands 16*(31-k) bits up so lane 0 is the MSBs.
  always_comb begin
    merged         = (lane == '0) ? '0 : pack.data;
    merged         = merged | (BEAT_W'(adc_data) << {LANE_W'(SPB - 1) - lane, 4'b0000});
    cur_beat.data  = merged;
    cur_beat.sop   = first_beat;
    cur_beat.eop   = final_sample;
    cur_beat.empty = final_sample ? empty_bytes(lane) : '0;
  end

  // A beat closing this cycle bypasses the pack register when the buffer has room.
  assign buf_in_valid = pack_full || close;
  assign buf_in       = pack_full ? pack : cur_beat;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      busy         <= 1'b0;
      left         <= '0;
      lane         <= '0;
      first_beat   <= 1'b0;
      pack         <= '0;
      pack_full    <= 1'b0;
      overflow_cnt <= '0;
      pkt_cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (trig && enable && (pkt_len != 16'd0)) begin
            state      <= CAPTURE;
            busy       <= 1'b1;
            left       <= pkt_len;
            lane       <= '0;
            first_beat <= 1'b1;
          end
        end
        CAPTURE: begin
          if (take && final_sample) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (eop_xfer) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase

      if (take) begin
        pack <= cur_beat;
        left <= left - 16'd1;
        lane <= close ? '0 : lane + 1'b1;
        if (close) begin
          first_beat <= 1'b0;
        end
      end

      if (close && !buf_in_ready) begin
        pack_full <= 1'b1;
      end else if (pack_full && buf_in_ready) begin
        pack_full <= 1'b0;
      end

      if (drop && (overflow_cnt != 32'hFFFF_FFFF)) begin
        overflow_cnt <= overflow_cnt + 32'd1;
      end

      if (eop_xfer) begin
        pkt_cnt <= pkt_cnt + 32'd1;
      end
    end
  end

  adc_beat_buf u_buf (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (buf_in_valid),
    .in_ready  (buf_in_ready),
    .in_beat   (buf_in),
    .out_valid (buf_out_valid),
    .out_ready (st.st_ready),
    .out_beat  (buf_out)
  );

  assign st.st_valid = buf_out_valid;
  assign st.st_data  = buf_out.data;
  assign st.st_sop   = buf_out.sop;
  assign st.st_eop   = buf_out.eop;
  assign st.st_empty = buf_out.empty;

endmodule

// File: tb/tb_adc_st_packetizer.sv
// tb/tb_adc_st_packetizer.sv - self-checking bench for adc_st_packetizer
module tb_adc_st_packetizer;
  import adc_st_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        trig;
  logic [15:0] pkt_len;
  logic [15:0] adc_data;
  logic        adc_valid;
  logic        busy;
  logic [31:0] ovf;
  logic [31:0] pcnt;

  adc_st_packetizer_if st_bus ();

  adc_st_packetizer dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .trig         (trig),
    .pkt_len      (pkt_len),
    .adc_data     (adc_data),
    .adc_valid    (adc_valid),
    .st           (st_bus.master),
    .busy         (busy),
    .overflow_cnt (ovf),
    .pkt_cnt      (pcnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: beat counts in buffer/pack plus a queue of expected beats.
  bit          m_busy, m_cap, m_P, m_first;
  int          m_left, m_B;
  logic [31:0] m_ovf, m_pkts;
  beat_t       exp_q[$];
  logic [15:0] cur_s[$];

  int          obs_beats, obs_sops;
  logic [5:0]  obs_last_empty;
  logic [15:0] obs_first_lane;
  logic        obs_first_sop;
  bit          obs_seen;

  typedef struct {
    int          len;
    int          stall;
    int          exp_beats;
    logic [5:0]  exp_empty;
    int          exp_drops;
    logic [15:0] exp_first;
  } vec_t;
  vec_t vecs[4];

  task automatic chk(input string name, input logic [BEAT_W-1:0] act, input logic [BEAT_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_update();
    int    b0;
    bit    p0, cap0, idle0, xfer;
    beat_t nb;
    if (reset) begin
      m_busy = 0; m_cap = 0; m_P = 0; m_first = 0; m_left = 0; m_B = 0;
      m_ovf = '0; m_pkts = '0;
      exp_q.delete(); cur_s.delete();
      return;
    end
    b0 = m_B; p0 = m_P; cap0 = m_cap; idle0 = !m_busy;
    xfer = (b0 > 0) && st_bus.st_ready;
    if (xfer && exp_q.size() > 0) begin
      if (exp_q[0].eop) begin
        m_busy = 0;
        m_pkts++;
      end
      void'(exp_q.pop_front());
    end
    if (cap0 && adc_valid) begin
      if (p0) begin
        if (m_ovf != 32'hFFFF_FFFF) m_ovf++;
      end else begin
        cur_s.push_back(adc_data);
        m_left--;
        if (cur_s.size() == SPB || m_left == 0) begin
          nb.data = '0;
          foreach (cur_s[k]) nb.data |= BEAT_W'(cur_s[k]) << (SAMPLE_W * (SPB - 1 - k));
          nb.sop   = m_first;
          nb.eop   = (m_left == 0);
          nb.empty = nb.eop ? EMPTY_W'(2 * (SPB - cur_s.size())) : '0;
          exp_q.push_back(nb);
          m_first = 0;
          cur_s.delete();
          if (b0 < 2) m_B++;
          else m_P = 1;
          if (m_left == 0) m_cap = 0;
        end
      end
    end
    if (p0 && b0 < 2) begin
      m_P = 0;
      m_B++;
    end
    if (xfer) m_B--;
    if (idle0 && trig && enable && pkt_len != 16'd0) begin
      m_busy = 1; m_cap = 1; m_left = pkt_len; m_first = 1;
    end
  endtask

  task automatic check_outputs();
    chk("st_valid", st_bus.st_valid, m_B > 0);
    chk("busy", busy, m_busy);
    chk("overflow_cnt", ovf, m_ovf);
    chk("pkt_cnt", pcnt, m_pkts);
    if (m_B > 0 && exp_q.size() > 0) begin
      chk("st_data", st_bus.st_data, exp_q[0].data);
      chk("st_sop", st_bus.st_sop, exp_q[0].sop);
      chk("st_eop", st_bus.st_eop, exp_q[0].eop);
      chk("st_empty", st_bus.st_empty, exp_q[0].empty);
    end
  endtask

  task automatic cycle();
    if (st_bus.st_valid && st_bus.st_ready) begin
      obs_beats++;
      if (st_bus.st_sop) obs_sops++;
      if (!obs_seen) begin
        obs_seen       = 1;
        obs_first_lane = st_bus.st_data[511:496];
        obs_first_sop  = st_bus.st_sop;
      end
      if (st_bus.st_eop) obs_last_empty = st_bus.st_empty;
    end
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic clear_obs();
    obs_beats = 0; obs_sops = 0; obs_seen = 0;
    obs_last_empty = 6'h3F; obs_first_lane = 16'hDEAD; obs_first_sop = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, st_bus.st_valid, 0);
    chk({tag, "_data"}, st_bus.st_data, 0);
    chk({tag, "_sop"}, st_bus.st_sop, 0);
    chk({tag, "_eop"}, st_bus.st_eop, 0);
    chk({tag, "_empty"}, st_bus.st_empty, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ovf"}, ovf, 0);
    chk({tag, "_pkt_cnt"}, pcnt, 0);
  endtask

  task automatic run_packet(input int len, input int stall);
    int k;
    clear_obs();
    enable = 1; trig = 1; pkt_len = 16'(len); adc_valid = 1; adc_data = 16'hFFFF;
    st_bus.st_ready = (stall == 0);
    cycle();
    trig = 0;
    k = 1;
    while (m_busy && k < 3000) begin
      adc_data = 16'(k - 1);
      st_bus.st_ready = (k >= stall);
      cycle();
      k++;
    end
    chk("packet_done", k < 3000, 1);
    adc_valid = 0;
    st_bus.st_ready = 1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ovf0, p0;

    vecs[0] = '{64,  0,   2, 6'd0,  0,   16'h0000};
    vecs[1] = '{40,  0,   2, 6'd48, 0,   16'h0000};
    vecs[2] = '{5,   0,   1, 6'd54, 0,   16'h0000};
    vecs[3] = '{128, 200, 4, 6'd0,  105, 16'h0000};

    reset = 1; enable = 0; trig = 0; pkt_len = 0; adc_data = 0; adc_valid = 0;
    st_bus.st_ready = 1;
    clear_obs();
    cycle();
    cycle();
    chk_zero("reset");
    reset = 0;
    cycle();

    foreach (vecs[i]) begin
      ovf0 = ovf;
      p0   = pcnt;
      run_packet(vecs[i].len, vecs[i].stall);
      chk("vec_beats", obs_beats, vecs[i].exp_beats);
      chk("vec_last_empty", obs_last_empty, vecs[i].exp_empty);
      chk("vec_drops", ovf - ovf0, vecs[i].exp_drops);
      chk("vec_first_lane", obs_first_lane, vecs[i].exp_first);
      chk("vec_first_sop", obs_first_sop, 1);
      chk("vec_sops", obs_sops, 1);
      chk("vec_pkt_cnt", pcnt - p0, 1);
      cycle();
    end

    // Retrigger mid-capture and enable dropped mid-packet.
    clear_obs();
    p0 = pcnt;
    enable = 1; trig = 1; pkt_len = 50; adc_valid = 1; adc_data = 0; st_bus.st_ready = 1;
    cycle();
    for (int k = 1; k < 300 && m_busy; k++) begin
      adc_data = 16'(k);
      trig     = (k == 10);
      pkt_len  = (k == 10) ? 16'd7 : 16'd50;
      enable   = (k < 20);
      cycle();
    end
    trig = 0;
    chk("retrig_sops", obs_sops, 1);
    chk("retrig_beats", obs_beats, 2);
    chk("retrig_empty", obs_last_empty, 28);
    chk("retrig_pkt_cnt", pcnt - p0, 1);
    enable = 0; trig = 1; pkt_len = 10;
    cycle();
    trig = 0;
    cycle();
    chk("disabled_trig_busy", busy, 0);
    enable = 1; trig = 1; pkt_len = 0;
    cycle();
    trig = 0;
    cycle();
    chk("zero_len_trig_busy", busy, 0);

    // Trigger coincident with the EOP transfer is ignored.
    enable = 1; trig = 1; pkt_len = 5; adc_valid = 1; st_bus.st_ready = 0;
    cycle();
    trig = 0;
    for (int k = 1; k < 10; k++) begin
      adc_data = 16'(16'h1000 + k);
      cycle();
    end
    chk("eop_held_valid", st_bus.st_valid, 1);
    trig = 1; st_bus.st_ready = 1;
    cycle();
    trig = 0; adc_valid = 0;
    chk("trig_at_eop_busy", busy, 0);
    cycle();
    chk("trig_at_eop_busy2", busy, 0);

    // Reset after 20 of 64 samples, then a clean packet.
    enable = 1; trig = 1; pkt_len = 64; adc_valid = 1;
    cycle();
    trig = 0;
    for (int k = 1; k <= 20; k++) begin
      adc_data = 16'(16'h2000 + k);
      cycle();
    end
    reset = 1;
    cycle();
    chk_zero("midreset");
    reset = 0;
    run_packet(64, 0);
    chk("post_reset_first_sop", obs_first_sop, 1);
    chk("post_reset_beats", obs_beats, 2);
    chk("post_reset_pkt_cnt", pcnt, 1);

    // Randomized traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      reset           = ($urandom_range(0, 499) == 0);
      enable          = ($urandom_range(0, 9) != 0);
      trig            = ($urandom_range(0, 19) == 0);
      pkt_len         = 16'($urandom_range(0, 80));
      adc_valid       = ($urandom_range(0, 9) < 7);
      adc_data        = 16'($urandom);
      st_bus.st_ready = ($urandom_range(0, 9) < 6);
      cycle();
    end
    reset = 0; trig = 0; adc_valid = 0; st_bus.st_ready = 1;
    for (int c = 0; c < 10; c++) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adc_st_packetizer.md
Name: adc_st_packetizer

Overview:
- Upstream feeder for the ADC FIFO's 512-bit Avalon-ST sink (data/valid/ready/startofpacket/endofpacket/empty[5:0]) inside soc_system.
- Accepts 16-bit ADC samples, captures pkt_len samples per trigger, and packs them 32 per beat.
- Emits framed packets with SOP/EOP/empty, honours ready backpressure, and counts samples dropped on overflow.

Parameters:
- SAMPLE_W, 16, ADC sample width in bits; fixed to 2 bytes per sample.
- BEAT_W, 512, output beat width in bits.
- SPB, BEAT_W/SAMPLE_W = 32, samples per beat (derived; not overridable).
- EMPTY_W, 6, width of the empty field (log2 of BEAT_W/8).

Ports:
- clk  in  1  single clock for all logic.
- reset  in  1  synchronous, active-high.
- enable  in  1  level; arms the block for triggers.
- trig  in  1  one-cycle pulse that starts a packet.
- pkt_len  in  16  samples per packet; latched on an accepted trigger.
- adc_data  in  16  ADC sample.
- adc_valid  in  1  adc_data is valid this cycle.
- st_data  out  512  Avalon-ST data toward adc_fifo sink.
- st_valid  out  1  beat valid.
- st_ready  in  1  sink ready (readyLatency 0).
- st_sop  out  1  first beat of packet.
- st_eop  out  1  last beat of packet.
- st_empty  out  6  unused bytes in the EOP beat; 0 on all other beats.
- busy  out  1  high in CAPTURE or DRAIN.
- overflow_cnt  out  32  samples dropped; saturating.
- pkt_cnt  out  32  packets whose EOP beat was transferred; wraps.

Behaviour:
- Reset values: all outputs 0; FSM = IDLE; pack register, lane index, sample counter and buffer cleared.
- Reset mid-packet: partial packet is discarded and no EOP is emitted.
- FSM states: IDLE, CAPTURE, DRAIN.
- IDLE -> CAPTURE when trig && enable && pkt_len != 0. pkt_len is latched and the sample counter is loaded with it. Triggers with pkt_len = 0 are ignored.
- trig is ignored while in CAPTURE or DRAIN.
- Sample acceptance: only adc_valid cycles strictly after the trig cycle are taken.
- Lane placement: sample k of a beat occupies st_data[511-16k -: 16], so the first sample sits in the MSBs.
- Unfilled lanes are 0.
- Beat close: a beat closes when lane 31 is filled or when the final sample (counter reaching 0) arrives.
- A closed beat moves into a 2-entry output buffer in the cycle after its last sample, carrying its sop/eop/empty tags.
- Tagging: sop is set on the first beat after trigger. eop and st_empty = 2*(32 - samples_in_beat) are set on the last beat. A 1-beat packet carries sop and eop together.
- CAPTURE -> DRAIN when the final sample is accepted.
- DRAIN -> IDLE when the EOP beat transfers (st_valid && st_ready). pkt_cnt increments in that same cycle.
- Overflow: if a beat is closed but the buffer is full, the pack register holds.
  - Any adc_valid sample arriving while the pack register is full is dropped and overflow_cnt increments; it saturates at 0xFFFFFFFF.
  - Dropped samples do not decrement the sample counter, so every packet always carries exactly pkt_len samples.
- Latency: the last sample of a beat is accepted in cycle N; st_valid is asserted in cycle N+1 if the buffer was empty.
- Handshake: st_data, st_sop, st_eop and st_empty stay stable while st_valid && !st_ready. st_valid never drops without a transfer.
- Throughput: one beat per cycle with st_ready held high. The buffer accepts a beat and releases one in the same cycle.
- enable deasserted mid-packet: the current packet completes normally; only new triggers are blocked.
- Simultaneous trig and EOP transfer in DRAIN: the trigger is ignored.
- busy: 1 in CAPTURE and DRAIN, 0 in IDLE.

Decomposition:
- Package adc_st_pkg holds:
  - constants SAMPLE_W, BEAT_W, SPB, EMPTY_W;
  - typedef state_t {IDLE, CAPTURE, DRAIN};
  - typedef beat_t struct {data[511:0], sop, eop, empty[5:0]}.
- One sub-module, adc_beat_buf: a 2-entry beat_t FIFO with valid/ready on both sides, zero-bubble, and registered outputs.
- The top level holds the FSM, the packer and the counters.

Test Plan:
- pkt_len=64, adc_valid every cycle, st_ready=1, samples 0..63 -> 2 beats. Beat0: sop=1, first lane 0x0000 at [511:496]. Beat1: eop=1, empty=0. pkt_cnt=1. overflow_cnt=0.
- pkt_len=40 -> beat1 holds samples 32..39 with eop=1 and empty=48; lanes below sample 39 are 0.
- pkt_len=5 -> a single beat with sop=eop=1 and empty=54. busy falls the cycle after the transfer.
- pkt_len=128, st_ready=0 for 200 cycles -> 2 beats buffered, pack register holds beat 2, overflow_cnt counts dropped samples. After st_ready=1, exactly 4 beats are delivered with 128 samples total, and data stays stable during the stall.
- trig pulsed again mid-CAPTURE, and enable dropped mid-packet -> a single packet of pkt_len samples; no second SOP until the next trig after IDLE.
- reset asserted after 20 of 64 samples -> all outputs 0 the next cycle. A new trig then produces a clean packet starting with sop=1.
